// File: rtl/instr_fetch.sv
// Instruction fetch unit: demand fetches from memory and, with INSTR_FETCH_PREFETCH_EN
// defined, a sequential prefetch queue of QDEPTH words with tag-matched hits.
module instr_fetch #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state_o
);

  // Memory handshake: mem_rd/mem_addr stay constant from issue until the edge
  // that samples mem_ack=1; that edge either drops mem_rd or starts the next read.
  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        req_ok;
  logic        misalign;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [31:0] tag_q [QDEPTH];
  logic [31:0] tag_d [QDEPTH];
  logic [31:0] dat_q [QDEPTH];
  logic [31:0] dat_d [QDEPTH];
  logic [2:0]  cnt_q, cnt_d;
  logic        base_vld_q, base_vld_d;
  logic [31:0] base_q, base_d;
  logic [31:0] dem_q, dem_d;
  logic        hit;
  logic [31:0] tail_tag;
  logic [31:0] pf_addr;

  // Queue holds consecutive words after the base, so the next prefetch follows the tail.
  always_comb begin
    tail_tag = base_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (3'(i + 1) == cnt_q) tail_tag = tag_q[i];
    end
    pf_addr = tail_tag + 32'd4;
  end

  assign hit = (cnt_q != 3'd0) && (tag_q[0] == fetch_addr);
`endif

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    tag_d      = tag_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    base_vld_d = base_vld_q;
    dem_d      = dem_q;
`endif
    req_ok   = fetch_req & ~busy_q;
    misalign = (fetch_addr[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        if (req_ok && misalign) begin
          err_d = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
        end else if (req_ok && hit) begin
          instr_d    = dat_q[0];
          valid_d    = 1'b1;
          base_d     = tag_q[0];
          base_vld_d = 1'b1;
          for (int i = 0; i < QDEPTH - 1; i++) begin
            tag_d[i] = tag_d[i + 1];
            dat_d[i] = dat_d[i + 1];
          end
          cnt_d = cnt_d - 3'd1;
`endif
        end else if (req_ok) begin
`ifdef INSTR_FETCH_PREFETCH_EN
          cnt_d = 3'd0;
`endif
          busy_d     = 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = fetch_addr;
          state_d    = DEMAND;
`ifdef INSTR_FETCH_PREFETCH_EN
        end else if (base_vld_q && (cnt_q < 3'(QDEPTH))) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = pf_addr;
          state_d    = PREFETCH;
`endif
        end
      end

      DEMAND: begin
        if (mem_ack) begin
          instr_d  = mem_rdata;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          mem_rd_d = 1'b0;
          state_d  = IDLE;
`ifdef INSTR_FETCH_PREFETCH_EN
          base_d     = mem_addr_q;
          base_vld_d = 1'b1;
`endif
        end
      end

`ifdef INSTR_FETCH_PREFETCH_EN
      PREFETCH: begin
        if (req_ok && !misalign && !hit) begin
          // Miss while a prefetch is outstanding: queue is stale either way.
          cnt_d  = 3'd0;
          busy_d = 1'b1;
          if (fetch_addr == mem_addr_q) begin
            if (mem_ack) begin
              instr_d    = mem_rdata;
              valid_d    = 1'b1;
              busy_d     = 1'b0;
              mem_rd_d   = 1'b0;
              base_d     = mem_addr_q;
              base_vld_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = DEMAND;
            end
          end else if (mem_ack) begin
            mem_addr_d = fetch_addr;
            mem_rd_d   = 1'b1;
            state_d    = DEMAND;
          end else begin
            dem_d   = fetch_addr;
            state_d = DRAIN;
          end
        end else begin
          if (req_ok && misalign) err_d = 1'b1;
          if (req_ok && hit) begin
            instr_d    = dat_q[0];
            valid_d    = 1'b1;
            base_d     = tag_q[0];
            base_vld_d = 1'b1;
            for (int i = 0; i < QDEPTH - 1; i++) begin
              tag_d[i] = tag_d[i + 1];
              dat_d[i] = dat_d[i + 1];
            end
            cnt_d = cnt_d - 3'd1;
          end
          if (mem_ack) begin
            for (int i = 0; i < QDEPTH; i++) begin
              if (3'(i) == cnt_d) begin
                tag_d[i] = mem_addr_q;
                dat_d[i] = mem_rdata;
              end
            end
            cnt_d    = cnt_d + 3'd1;
            mem_rd_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      DRAIN: begin
        if (mem_ack) begin
          mem_addr_d = dem_q;
          mem_rd_d   = 1'b1;
          state_d    = DEMAND;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      for (int i = 0; i < QDEPTH; i++) begin
        tag_q[i] <= 32'd0;
        dat_q[i] <= 32'd0;
      end
      cnt_q      <= 3'd0;
      base_vld_q <= 1'b0;
      base_q     <= 32'd0;
      dem_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      tag_q      <= tag_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      base_vld_q <= base_vld_d;
      base_q     <= base_d;
      dem_q      <= dem_d;
`endif
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_busy  = busy_q;
  assign fetch_err   = err_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; covers both the demand-only and prefetch builds.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] S_IDLE     = 32'd0;
  localparam logic [31:0] S_DEMAND   = 32'd1;
  localparam logic [31:0] S_PREFETCH = 32'd2;
  localparam logic [31:0] S_DRAIN    = 32'd3;

  localparam logic [31:0] D0  = 32'h2820002B;
  localparam logic [31:0] D4  = 32'h00A00093;
  localparam logic [31:0] D8  = 32'h00B00113;
  localparam logic [31:0] DC  = 32'hDEADC0DE;
  localparam logic [31:0] DJ  = 32'h13579BDF;
  localparam logic [31:0] DW  = 32'hFFFF0001;
  localparam logic [31:0] DZ  = 32'h0BADF00D;
  localparam logic [31:0] DF  = 32'h44440004;

  always #5 clk = ~clk;

  instr_fetch #(.QDEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .dbg_state_o (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a read, checks its address and that it holds, then acks once.
  task automatic mem_serve(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] data, input int lat);
    int n;
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rd"}, 32'(mem_rd), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    for (int i = 0; i < lat; i++) begin
      step();
      chk({tag, "_hold"}, mem_addr, exp_addr);
    end
    mem_rdata = data;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 32'd0;
    mem_rdata  = 32'd0;
    mem_ack    = 1'b0;
    step();
    step();
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_state", 32'(dbg_state), S_IDLE);

    // First demand, acked two cycles after issue.
    reset = 1'b0;
    step();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0000;
    step();
    fetch_req = 1'b0;
    chk("d0_busy", 32'(fetch_busy), 32'd1);
    chk("d0_state", 32'(dbg_state), S_DEMAND);
    chk("d0_rd", 32'(mem_rd), 32'd1);
    chk("d0_addr", mem_addr, 32'd0);
    step();
    step();
    chk("d0_rd_hold", 32'(mem_rd), 32'd1);
    mem_rdata = D0;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    chk("d0_valid", 32'(instr_valid), 32'd1);
    chk("d0_instr", instruction, D0);
    chk("d0_busy_low", 32'(fetch_busy), 32'd0);
    chk("d0_rd_drop", 32'(mem_rd), 32'd0);
    step();
    chk("d0_pulse", 32'(instr_valid), 32'd0);
    chk("d0_instr_hold", instruction, D0);

`ifdef INSTR_FETCH_PREFETCH_EN
    mem_serve("pf4", 32'h4, D4, 1);
    mem_serve("pf8", 32'h8, D8, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_no_pf", 32'(mem_rd), 32'd0);
    end
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    step();
    fetch_req = 1'b0;
    chk("hit4_valid", 32'(instr_valid), 32'd1);
    chk("hit4_instr", instruction, D4);
    chk("hit4_no_rd", 32'(mem_rd), 32'd0);
    chk("hit4_busy", 32'(fetch_busy), 32'd0);
    step();
    chk("pfc_rd", 32'(mem_rd), 32'd1);
    chk("pfc_addr", mem_addr, 32'hC);
    chk("pfc_state", 32'(dbg_state), S_PREFETCH);
    fetch_req  = 1'b1;
    fetch_addr = 32'h03ACD1E8;
    step();
    fetch_req = 1'b0;
    chk("jmp_state", 32'(dbg_state), S_DRAIN);
    chk("jmp_busy", 32'(fetch_busy), 32'd1);
    chk("jmp_addr_hold", mem_addr, 32'hC);
    mem_rdata = DC;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    chk("drain_discard_valid", 32'(instr_valid), 32'd0);
    chk("drain_discard_instr", instruction, D4);
    chk("drain_reissue_rd", 32'(mem_rd), 32'd1);
    chk("drain_reissue_addr", mem_addr, 32'h03ACD1E8);
    chk("drain_state", 32'(dbg_state), S_DEMAND);
    mem_serve("jmp", 32'h03ACD1E8, DJ, 1);
    chk("jmp_valid", 32'(instr_valid), 32'd1);
    chk("jmp_instr", instruction, DJ);
    chk("jmp_busy_low", 32'(fetch_busy), 32'd0);
    mem_serve("pf_after_flush", 32'h03ACD1EC, 32'h1, 0);
    mem_serve("pf_after_flush2", 32'h03ACD1F0, 32'h2, 0);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_pf", 32'(mem_rd), 32'd0);
    end
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    step();
    fetch_req = 1'b0;
    chk("d4_busy", 32'(fetch_busy), 32'd1);
    chk("d4_valid_early", 32'(instr_valid), 32'd0);
    mem_serve("d4", 32'h4, D4, 0);
    chk("d4_valid", 32'(instr_valid), 32'd1);
    chk("d4_instr", instruction, D4);
    chk("d4_rd_drop", 32'(mem_rd), 32'd0);
    step();
    fetch_req  = 1'b1;
    fetch_addr = 32'h03ACD1E8;
    step();
    fetch_req = 1'b0;
    mem_serve("jmp", 32'h03ACD1E8, DJ, 1);
    chk("jmp_valid", 32'(instr_valid), 32'd1);
    chk("jmp_instr", instruction, DJ);
`endif

    // Misaligned demand: error pulse only.
    fetch_req  = 1'b1;
    fetch_addr = 32'h6;
    step();
    fetch_req = 1'b0;
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_rd", 32'(mem_rd), 32'd0);
    chk("mis_instr", instruction, DJ);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    chk("mis_busy", 32'(fetch_busy), 32'd0);
    step();
    chk("mis_err_pulse", 32'(fetch_err), 32'd0);
    chk("mis_rd_after", 32'(mem_rd), 32'd0);

    // Top-of-memory delivery; next sequential address wraps to zero.
    fetch_req  = 1'b1;
    fetch_addr = 32'hFFFF_FFFC;
    step();
    fetch_req = 1'b0;
    chk("wrap_busy", 32'(fetch_busy), 32'd1);
    mem_serve("wrap_dem", 32'hFFFF_FFFC, DW, 1);
    chk("wrap_valid", 32'(instr_valid), 32'd1);
    chk("wrap_instr", instruction, DW);
`ifdef INSTR_FETCH_PREFETCH_EN
    mem_serve("wrap_pf", 32'h0, DZ, 0);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    chk("hit0_valid", 32'(instr_valid), 32'd1);
    chk("hit0_instr", instruction, DZ);
    chk("hit0_no_rd", 32'(mem_rd), 32'd0);
    step();
    chk("fwd_pf_rd", 32'(mem_rd), 32'd1);
    chk("fwd_pf_addr", mem_addr, 32'h4);
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    step();
    fetch_req = 1'b0;
    chk("fwd_busy", 32'(fetch_busy), 32'd1);
    chk("fwd_state", 32'(dbg_state), S_DEMAND);
    chk("fwd_valid_early", 32'(instr_valid), 32'd0);
    mem_rdata = DF;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    chk("fwd_valid", 32'(instr_valid), 32'd1);
    chk("fwd_instr", instruction, DF);
    chk("fwd_busy_low", 32'(fetch_busy), 32'd0);
    chk("fwd_rd_drop", 32'(mem_rd), 32'd0);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wrap_no_pf", 32'(mem_rd), 32'd0);
    end
`endif

    // Reset in the middle of an outstanding read; a stale ack must be ignored.
    fetch_req  = 1'b1;
    fetch_addr = 32'h100;
    step();
    fetch_req = 1'b0;
    chk("mid_rd", 32'(mem_rd), 32'd1);
    chk("mid_addr", mem_addr, 32'h100);
    reset = 1'b1;
    #1;
    chk("async_rd", 32'(mem_rd), 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    chk("async_busy", 32'(fetch_busy), 32'd0);
    chk("async_instr", instruction, 32'd0);
    chk("async_state", 32'(dbg_state), S_IDLE);
    step();
    reset = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_instr", instruction, 32'd0);
    chk("late_ack_rd", 32'(mem_rd), 32'd0);
    step();
    chk("late_ack_valid2", 32'(instr_valid), 32'd0);
    chk("post_rst_no_pf", 32'(mem_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, prefetch queue depth in words (legal values 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port fetch_req  input  1  processor demand fetch request, sampled only while fetch_busy=0.
REQ-005 SHALL have port fetch_addr  input  32  byte address of the demanded instruction; the processor holds it stable while fetch_busy=1.
REQ-006 SHALL have port instruction  output  32  fetched word, feeding the processor instruction input; holds its value until the next delivery.
REQ-007 SHALL have port instr_valid  output  1  one-cycle pulse marking a new instruction.
REQ-008 SHALL have port fetch_busy  output  1  demand accepted and not yet delivered.
REQ-009 SHALL have port fetch_err  output  1  one-cycle pulse on a misaligned demand.
REQ-010 SHALL have ports mem_rd (output, 1), mem_addr (output, 32), mem_rdata (input, 32) and mem_ack (input, 1), forming the memory read handshake.

Function
REQ-011 SHALL implement FSM states IDLE, DEMAND, PREFETCH and DRAIN.
REQ-012 Memory handshake: mem_rd and mem_addr SHALL be held stable until mem_ack is sampled high; mem_rd SHALL drop in the cycle after the ack; a read SHALL never be abandoned once issued.
REQ-013 A demand with fetch_addr[1:0]!=0 SHALL pulse fetch_err the next cycle, SHALL NOT access memory, and SHALL leave the queue unchanged.
REQ-014 Hit: if the queue head is valid and its tag equals fetch_addr, the head SHALL be popped and instruction/instr_valid SHALL update on the next edge (1-cycle latency).
REQ-015 Miss in IDLE: the queue SHALL flush, fetch_busy=1, and the FSM SHALL enter DEMAND with mem_addr=fetch_addr.
REQ-016 On ack in DEMAND, the block SHALL register instruction=mem_rdata with instr_valid=1 on the following edge, then return to IDLE; latency is ack cycle + 1.
REQ-017 Prefetch base: the address of the last delivered word SHALL be the prefetch base; next prefetch address = tail tag + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 In IDLE, with the base valid, the queue not full and no demand, the FSM SHALL enter PREFETCH; on ack the word SHALL be pushed at the tail with its tag.
REQ-019 When a demand arrives during PREFETCH and the in-flight address equals fetch_addr, the returning data SHALL be forwarded directly to instruction and SHALL NOT be queued.
REQ-020 When a demand arrives during PREFETCH with a different address (jump), the queue SHALL flush, the FSM SHALL enter DRAIN, the returning data SHALL be discarded, and DEMAND SHALL be issued in the cycle after the ack.
REQ-021 A demand that hits while a prefetch is in flight SHALL be served from the queue; the in-flight prefetch SHALL complete and push normally.
REQ-022 With the queue full, no prefetch SHALL be issued.
REQ-023 The queue SHALL NOT hold duplicate tags.
REQ-024 fetch_busy SHALL be 1 from the edge accepting a miss through the edge asserting instr_valid.

Reset
REQ-025 On reset=1, the block SHALL immediately drive instruction=0, instr_valid=0, fetch_busy=0, fetch_err=0, mem_rd=0 and mem_addr=0, set FSM=IDLE, invalidate all queue entries and invalidate the prefetch base.
REQ-026 On reset asserted mid-transaction, the block SHALL drop mem_rd asynchronously and ignore any later mem_ack until a new read is issued.

Configuration
REQ-027 Macro INSTR_FETCH_PREFETCH_EN: when defined, the queue and the PREFETCH/DRAIN states SHALL exist as specified; when undefined, every demand SHALL go to memory (DEMAND only), QDEPTH SHALL be ignored, and instr_valid latency SHALL remain ack+1.

Verification
REQ-028 Scenario: reset, demand 0x00000000, memory acks after 2 cycles with data 0x2820002B -> instruction=0x2820002B, instr_valid pulse at ack+1, fetch_busy low afterward.
REQ-029 Scenario: after the above, idle 10 cycles -> prefetches of 0x4 and 0x8; a demand of 0x4 yields instr_valid 1 cycle later with no mem_rd.
REQ-030 Scenario: a demand of 0x03ACD1E8 while a prefetch of 0xC is in flight -> 0xC data discarded, the next mem_addr is 0x03ACD1E8, and the queue is empty before the refill.
REQ-031 Scenario: a demand of 0x00000006 -> fetch_err pulse, mem_rd stays 0, instruction unchanged.
REQ-032 Scenario: deliver 0xFFFFFFFC, then allow prefetch -> prefetch mem_addr=0x00000000.
REQ-033 Scenario: reset asserted while mem_rd=1 -> mem_rd=0 in the same cycle, and a late mem_ack produces no instr_valid.
